// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_pkg
//  Description : Shared definitions for the LIF neuron block: FSM state
//                encoding, default parameter constants and a helper that
//                counts simultaneous synaptic events.
//  Revision    : 1.0 - initial release
// ============================================================================
package neuron_pkg;

    // Default parameter values shared by the neuron, its interface and benches
    localparam int c_W_DEF          = 8;
    localparam int c_THRESHOLD_DEF  = 200;
    localparam int c_WEIGHT_DEF     = 40;
    localparam int c_LEAK_SHIFT_DEF = 3;
    localparam int c_REFRACTORY_DEF = 4;
    localparam int c_NUM_SYN        = 4;

    typedef enum logic [1:0] {
        ST_INTEGRATE  = 2'd0,
        ST_FIRE       = 2'd1,
        ST_REFRACTORY = 2'd2
    } neuron_state_t;

    // Number of synapses that produced an event this cycle (0..4)
    function automatic logic [2:0] count_events(input logic [c_NUM_SYN-1:0] ev);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < c_NUM_SYN; i++) begin
            n = n + {2'b00, ev[i]};
        end
        return n;
    endfunction

endpackage : neuron_pkg
`default_nettype wire

// File: rtl/lif_neuron_if.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron_if
//  Description : Signal bundle between a LIF neuron and its environment.
//                master : drives en / spike_in, observes the neuron outputs
//                slave  : the neuron itself
//  Signals     : en         - integration enable
//                spike_in   - four asynchronous synaptic spike lines
//                spike_out  - one-cycle postsynaptic spike pulse
//                membrane   - membrane potential, W bits
//                refractory - high while the neuron is refractory
//  Revision    : 1.0 - initial release
// ============================================================================
interface lif_neuron_if
    import neuron_pkg::*;
#(
    parameter int W = c_W_DEF
) ();
    logic                 en;
    logic [c_NUM_SYN-1:0] spike_in;
    logic                 spike_out;
    logic [W-1:0]         membrane;
    logic                 refractory;

    modport master (
        output en,
        output spike_in,
        input  spike_out,
        input  membrane,
        input  refractory
    );

    modport slave (
        input  en,
        input  spike_in,
        output spike_out,
        output membrane,
        output refractory
    );
endinterface : lif_neuron_if
`default_nettype wire

// File: rtl/spike_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spike_sync_edge
//  Description : Two-flop synchroniser followed by a rising-edge detector for
//                one asynchronous spike line. o_event is a one-cycle pulse,
//                valid combinationally after the second synchroniser stage,
//                so a rise is seen by downstream logic on the 3rd clk edge.
//  Ports       : clk, rst (async, active-high), i_spike (async input),
//                o_event (one pulse per rising edge of i_spike)
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_sync_edge (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_spike,
    output logic o_event
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_spike;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_event = r_sync2 & ~r_prev;

endmodule : spike_sync_edge
`default_nettype wire

// File: rtl/lif_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron
//  Description : Leaky integrate-and-fire neuron with four synapses.
//                Each cycle in INTEGRATE (en=1) the membrane leaks by
//                v >> LEAK_SHIFT, gains WEIGHT per synaptic event, saturates
//                at 2^W-1 and fires when the result reaches THRESHOLD. A fire
//                gives a one-cycle spike_out, then REFRACTORY cycles during
//                which the membrane is held at 0 and events are dropped.
//  Ports       : clk, rst (async, active-high), bus (lif_neuron_if.slave:
//                en, spike_in[3:0], spike_out, membrane[W-1:0], refractory)
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron
    import neuron_pkg::*;
#(
    parameter int W          = c_W_DEF,
    parameter int THRESHOLD  = c_THRESHOLD_DEF,
    parameter int WEIGHT     = c_WEIGHT_DEF,
    parameter int LEAK_SHIFT = c_LEAK_SHIFT_DEF,
    parameter int REFRACTORY = c_REFRACTORY_DEF
) (
    input wire          clk,
    input wire          rst,
    lif_neuron_if.slave bus
);
    // Counter only needs to reach REFRACTORY-1; keep at least one bit so the
    // REFRACTORY=0 build still has a legal vector.
    localparam int            c_CNT_W      = (REFRACTORY > 1) ? $clog2(REFRACTORY) : 1;
    localparam int            c_REF_LOAD   = (REFRACTORY > 0) ? REFRACTORY - 1 : 0;
    localparam logic [W-1:0]  c_THRESH     = W'(THRESHOLD);
    localparam logic [W+2:0]  c_WEIGHT_EXT = (W+3)'(WEIGHT);

    neuron_state_t          r_state;
    logic [W-1:0]           r_membrane;
    logic                   r_spike;
    logic                   r_refr;
    logic [c_CNT_W-1:0]     r_cnt;

    logic [c_NUM_SYN-1:0]   w_event;
    logic [2:0]             w_count;
    logic [W-1:0]           w_leaked;
    logic [W+2:0]           w_sum;
    logic [W-1:0]           w_sat;
    logic                   w_fire;

    generate
        for (genvar i = 0; i < c_NUM_SYN; i++) begin : g_sync
            spike_sync_edge u_sync (
                .clk     (clk),
                .rst     (rst),
                .i_spike (bus.spike_in[i]),
                .o_event (w_event[i])
            );
        end
    endgenerate

    // v >> LEAK_SHIFT never exceeds v, so the subtraction cannot underflow
    assign w_leaked = r_membrane - (r_membrane >> LEAK_SHIFT);
    assign w_count  = count_events(w_event);
    // Three guard bits hold leaked + 4*WEIGHT before saturation
    assign w_sum    = {3'b000, w_leaked} + ({{W{1'b0}}, w_count} * c_WEIGHT_EXT);
    assign w_sat    = (|w_sum[W+2:W]) ? {W{1'b1}} : w_sum[W-1:0];
    assign w_fire   = (w_sat >= c_THRESH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INTEGRATE;
            r_membrane <= '0;
            r_spike    <= 1'b0;
            r_refr     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_INTEGRATE: begin
                    // en=0 freezes the membrane; events of this cycle are lost
                    if (bus.en) begin
                        if (w_fire) begin
                            r_membrane <= '0;
                            r_spike    <= 1'b1;
                            r_state    <= ST_FIRE;
                        end else begin
                            r_membrane <= w_sat;
                        end
                    end
                end
                ST_FIRE: begin
                    r_spike <= 1'b0;
                    if (REFRACTORY > 0) begin
                        r_refr  <= 1'b1;
                        r_cnt   <= c_CNT_W'(c_REF_LOAD);
                        r_state <= ST_REFRACTORY;
                    end else begin
                        r_state <= ST_INTEGRATE;
                    end
                end
                ST_REFRACTORY: begin
                    r_membrane <= '0;
                    if (r_cnt == '0) begin
                        r_refr  <= 1'b0;
                        r_state <= ST_INTEGRATE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_membrane <= '0;
                    r_spike    <= 1'b0;
                    r_refr     <= 1'b0;
                    r_state    <= ST_INTEGRATE;
                end
            endcase
        end
    end

    assign bus.spike_out  = r_spike;
    assign bus.membrane   = r_membrane;
    assign bus.refractory = r_refr;

endmodule : lif_neuron
`default_nettype wire
